mul_sequencer: RTL

Iterative shift-add multiplier controller for the pipelined ARM core's Execute stage. It accepts one multiply (MUL, and with the long option UMULL/SMULL) from Execute and runs it radix-2 over WIDTH cycles. While it runs, it requests a pipeline stall. When finished, it presents the result with its destination register tags to the writeback path. It replaces a single-cycle array multiplier to save area, and shares one adder between all multiply instructions.

---
 rtl/mul_sequencer_if.sv | 32 +++
 rtl/mul_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer_if.sv
// Multiply request/result bundle between Execute, the hazard unit and writeback.
// master: Execute/hazard side driving requests; slave: the mul_sequencer.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             StartE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             SignedE;
  logic             LongE;
  logic [3:0]       RdLoE;
  logic [3:0]       RdHiE;
  logic             FlushE;
  logic             MulStall;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ResultLo;
  logic [WIDTH-1:0] ResultHi;
  logic [3:0]       RdLo;
  logic [3:0]       RdHi;
  logic             WriteHi;

  modport master (
    output StartE, SrcAE, SrcBE, SignedE, LongE, RdLoE, RdHiE, FlushE,
    input  MulStall, Busy, Done, ResultLo, ResultHi, RdLo, RdHi, WriteHi
  );

  modport slave (
    input  StartE, SrcAE, SrcBE, SignedE, LongE, RdLoE, RdHiE, FlushE,
    output MulStall, Busy, Done, ResultLo, ResultHi, RdLo, RdHi, WriteHi
  );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative radix-2 shift-add multiplier controller for the Execute stage.
// One multiply runs over WIDTH cycles on a single shared adder; the pipeline
// is stalled while it runs and the result is presented for one cycle in DONE.
// Optional feature macro: MUL_LONG_EN builds UMULL/SMULL support (signed
// operands, full 2*WIDTH product with final negation, WriteHi/ResultHi).
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mul_sequencer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [3:0]       rd_lo_reg;
  logic [3:0]       rd_hi_reg;
  logic             done_reg;
  logic [WIDTH-1:0] res_lo_reg;

  logic             accept;
  logic             last;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] final_lo;

`ifdef MUL_LONG_EN
  logic             sign_reg;
  logic             long_reg;
  logic [WIDTH-1:0] res_hi_reg;
  logic [WIDTH-1:0] final_hi;
  logic             sign_in;
`else
  logic             unused_mode;
`endif

  assign accept = (state_reg == IDLE) & bus.StartE & ~bus.FlushE;
  assign last   = (count_reg == CW'(WIDTH - 1));

  // One iteration: add the multiplicand when lo[0] is set, then shift {carry,hi,lo} right
  always_comb begin
    sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
    hi_next = sum[WIDTH:1];
    lo_next = {sum[0], lo_reg[WIDTH-1:1]};
  end

`ifdef MUL_LONG_EN
  // Signed operands run as magnitudes; the sign is reapplied to the full product at the end.
  // The most-negative value negates to itself, which is exactly its unsigned magnitude.
  always_comb begin
    sign_in = bus.SignedE & (bus.SrcAE[WIDTH-1] ^ bus.SrcBE[WIDTH-1]);
    mag_a   = (bus.SignedE & bus.SrcAE[WIDTH-1]) ? -bus.SrcAE : bus.SrcAE;
    mag_b   = (bus.SignedE & bus.SrcBE[WIDTH-1]) ? -bus.SrcBE : bus.SrcBE;
    {final_hi, final_lo} = sign_reg ? -{hi_next, lo_next} : {hi_next, lo_next};
  end
`else
  // Short build: unsigned product only; its low half equals the signed MUL result
  always_comb begin
    mag_a    = bus.SrcAE;
    mag_b    = bus.SrcBE;
    final_lo = lo_next;
  end
  assign unused_mode = bus.SignedE ^ bus.LongE;
`endif

  // Sequencer FSM with datapath and registered result/tag outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      mcand_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      rd_lo_reg  <= '0;
      rd_hi_reg  <= '0;
      done_reg   <= 1'b0;
      res_lo_reg <= '0;
`ifdef MUL_LONG_EN
      sign_reg   <= 1'b0;
      long_reg   <= 1'b0;
      res_hi_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (accept) begin
            mcand_reg <= mag_a;
            lo_reg    <= mag_b;
            hi_reg    <= '0;
            count_reg <= '0;
            rd_lo_reg <= bus.RdLoE;
            rd_hi_reg <= bus.RdHiE;
`ifdef MUL_LONG_EN
            sign_reg  <= sign_in;
            long_reg  <= bus.LongE;
`endif
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (bus.FlushE) begin
            // Killed instruction: abandon quietly, no Done
            state_reg <= IDLE;
          end else begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
            if (last) begin
              state_reg  <= DONE;
              done_reg   <= 1'b1;
              res_lo_reg <= final_lo;
`ifdef MUL_LONG_EN
              res_hi_reg <= final_hi;
`endif
            end else begin
              count_reg <= count_reg + CW'(1);
            end
          end
        end
        DONE: begin
          // Already committed: FlushE has no effect here
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.MulStall = ~bus.FlushE &
                        (((state_reg == IDLE) & bus.StartE) | (state_reg == RUN));
  assign bus.Busy     = (state_reg != IDLE);
  assign bus.Done     = done_reg;
  assign bus.ResultLo = res_lo_reg;
  assign bus.RdLo     = rd_lo_reg;
  assign bus.RdHi     = rd_hi_reg;
`ifdef MUL_LONG_EN
  assign bus.ResultHi = res_hi_reg;
  assign bus.WriteHi  = long_reg;
`else
  assign bus.ResultHi = '0;
  assign bus.WriteHi  = 1'b0;
`endif

endmodule
